// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port; gnt is combinational, rvalid lands MEM_LAT+1 cycles after gnt.
// One transaction at a time: losers see gnt low until IDLE. Optional ARB_ROUND_ROBIN_EN selects round-robin over data priority.
module mem_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [D_WIDTH-1:0] if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [D_WIDTH-1:0] if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [D_WIDTH-1:0] d_addr,
    input  logic [D_WIDTH-1:0] d_wdata,
    input  logic [2:0]         d_funct3,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [D_WIDTH-1:0] d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic [2:0]         mem_funct3,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic               owner_d;
    logic               we_q;
    logic [D_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic [2:0]         f3_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic               busy_q;
    logic               if_rvalid_q;
    logic               d_rvalid_q;
    logic [D_WIDTH-1:0] if_rdata_q;
    logic [D_WIDTH-1:0] d_rdata_q;
    logic               pick_d;
    logic               grant;
    logic               capture;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // Tie goes to whichever port did not win last; reset value means data wins first.
    assign pick_d = d_req & (~if_req | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (grant) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign grant   = (state == IDLE) & (if_req | d_req);
    // rst_n gating keeps the combinational grants at 0 while reset is held.
    assign d_gnt   = rst_n & grant & pick_d;
    assign if_gnt  = rst_n & grant & ~pick_d;
    assign capture = ((state == ACCESS) && (MEM_LAT == 1)) ||
                     ((state == WAIT) && (cnt == WAIT_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            owner_d     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= 3'b000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= ACCESS;
                        owner_d  <= pick_d;
                        mem_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        if (pick_d) begin
                            we_q     <= d_we;
                            addr_q   <= d_addr;
                            wdata_q  <= d_wdata;
                            f3_q     <= d_funct3;
                            mem_we_q <= d_we;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            f3_q    <= 3'b010;
                        end
                    end
                end
                ACCESS: begin
                    if (MEM_LAT == 1) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    cnt    <= 4'd0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Read data is sampled on the edge that enters RESP; writes return 0.
            if (capture) begin
                if (owner_d) begin
                    d_rdata_q  <= we_q ? '0 : mem_rdata;
                    d_rvalid_q <= 1'b1;
                end else begin
                    if_rdata_q  <= mem_rdata;
                    if_rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = f3_q;
    assign busy       = busy_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign d_rvalid   = d_rvalid_q;
    assign d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4) checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;
    localparam int NI = 3;

    logic        clk;
    logic        rst_n;
    logic        if_req     [NI];
    logic [31:0] if_addr    [NI];
    logic        if_gnt     [NI];
    logic        if_rvalid  [NI];
    logic [31:0] if_rdata   [NI];
    logic        d_req      [NI];
    logic        d_we       [NI];
    logic [31:0] d_addr     [NI];
    logic [31:0] d_wdata    [NI];
    logic [2:0]  d_funct3   [NI];
    logic        d_gnt      [NI];
    logic        d_rvalid   [NI];
    logic [31:0] d_rdata    [NI];
    logic        mem_en     [NI];
    logic        mem_we     [NI];
    logic [31:0] mem_addr   [NI];
    logic [31:0] mem_wdata  [NI];
    logic [2:0]  mem_funct3 [NI];
    logic [31:0] mem_rdata  [NI];
    logic        busy       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .D_WIDTH(32),
            .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_funct3  (d_funct3[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_funct3(mem_funct3[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // Model: a transaction granted at cycle s shows mem_en at s+1, busy over s+1..s+L+1,
    // rvalid at s+L+1, and samples mem_rdata during cycle s+L.
    typedef struct {
        bit          valid;
        int          start;
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } txn_t;

    txn_t        cur    [NI];
    logic [31:0] lat_a  [NI];
    logic [31:0] lat_w  [NI];
    logic [2:0]  lat_f  [NI];
    logic [31:0] rd_i   [NI];
    logic [31:0] rd_d   [NI];
    bit          last_d [NI];
    bit          hold   [NI];
    int          cyc;
    int          n_chk;
    int          n_fail;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d cycle %0d %s: got 0x%0h, want 0x%0h", i, cyc, nm, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        cur[i].valid = 1'b0;
        lat_a[i] = '0;
        lat_w[i] = '0;
        lat_f[i] = '0;
        rd_i[i] = '0;
        rd_d[i] = '0;
        last_d[i] = 1'b0;
    endtask

    task automatic model_cycle();
        for (int i = 0; i < NI; i++) begin
            int L;
            int k;
            bit g;
            bit gd;
            L  = lat_of(i);
            g  = 1'b0;
            gd = 1'b0;
            if (!rst_n) begin
                model_reset(i);
            end else begin
                if (cur[i].valid && (cyc - cur[i].start > L + 1)) cur[i].valid = 1'b0;
                if (!cur[i].valid && (if_req[i] || d_req[i])) begin
                    g = 1'b1;
                    if (if_req[i] && d_req[i]) begin
`ifdef ARB_ROUND_ROBIN_EN
                        gd = !last_d[i];
`else
                        gd = 1'b1;
`endif
                    end else begin
                        gd = d_req[i];
                    end
                    cur[i].valid  = 1'b1;
                    cur[i].start  = cyc;
                    cur[i].port_d = gd;
                    cur[i].we     = gd ? d_we[i] : 1'b0;
                    cur[i].addr   = gd ? d_addr[i] : if_addr[i];
                    cur[i].wdata  = gd ? d_wdata[i] : 32'h0;
                    cur[i].f3     = gd ? d_funct3[i] : 3'b010;
                end
            end
            k = cur[i].valid ? (cyc - cur[i].start) : -1;
            chk(i, "if_gnt",     32'(if_gnt[i]),    32'(g && !gd));
            chk(i, "d_gnt",      32'(d_gnt[i]),     32'(g && gd));
            chk(i, "mem_en",     32'(mem_en[i]),    32'(k == 1));
            chk(i, "mem_we",     32'(mem_we[i]),    32'(k == 1 && cur[i].we));
            chk(i, "busy",       32'(busy[i]),      32'(k >= 1 && k <= L + 1));
            chk(i, "if_rvalid",  32'(if_rvalid[i]), 32'(k == L + 1 && !cur[i].port_d));
            chk(i, "d_rvalid",   32'(d_rvalid[i]),  32'(k == L + 1 && cur[i].port_d));
            chk(i, "mem_addr",   mem_addr[i],       lat_a[i]);
            chk(i, "mem_wdata",  mem_wdata[i],      lat_w[i]);
            chk(i, "mem_funct3", 32'(mem_funct3[i]), 32'(lat_f[i]));
            chk(i, "if_rdata",   if_rdata[i],       rd_i[i]);
            chk(i, "d_rdata",    d_rdata[i],        rd_d[i]);
            if (g) begin
                lat_a[i]  = cur[i].addr;
                lat_w[i]  = cur[i].wdata;
                lat_f[i]  = cur[i].f3;
                last_d[i] = gd;
            end
            if (k == L) begin
                if (cur[i].port_d) rd_d[i] = cur[i].we ? 32'h0 : mem_rdata[i];
                else               rd_i[i] = mem_rdata[i];
            end
        end
        cyc++;
    endtask

    // Ends one cycle: model check at the falling edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            if (!hold[i]) mem_rdata[i] = 32'h5A00_0000 ^ (32'(cyc) * 32'h0101_0101) ^ 32'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bit gport [6];
        int gtime [6];
        int ng;
        bit seen_i;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b0;   if_addr[i] = '0;
            d_req[i] = 1'b0;    d_we[i] = 1'b0;    d_addr[i] = '0;
            d_wdata[i] = '0;    d_funct3[i] = '0;  mem_rdata[i] = '0;
            hold[i] = 1'b0;
            model_reset(i);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Lone fetch at MEM_LAT=1
        hold[0] = 1'b1; mem_rdata[0] = 32'hDEADBEEF;
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        #1 chk(0, "s1_if_gnt_c0", 32'(if_gnt[0]), 32'd1);
        chk(0, "s1_busy_c0", 32'(busy[0]), 32'd0);
        tick(); if_req[0] = 1'b0;
        #1 chk(0, "s1_mem_en_c1", 32'(mem_en[0]), 32'd1);
        chk(0, "s1_mem_addr_c1", mem_addr[0], 32'h100);
        chk(0, "s1_busy_c1", 32'(busy[0]), 32'd1);
        tick();
        #1 chk(0, "s1_if_rvalid_c2", 32'(if_rvalid[0]), 32'd1);
        chk(0, "s1_if_rdata_c2", if_rdata[0], 32'hDEADBEEF);
        chk(0, "s1_busy_c2", 32'(busy[0]), 32'd1);
        tick();
        #1 chk(0, "s1_busy_c3", 32'(busy[0]), 32'd0);
        hold[0] = 1'b0;
        idle(2);

        // Data read then data write at MEM_LAT=3
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h44; d_funct3[1] = 3'b100;
        #1 chk(1, "s2a_d_gnt", 32'(d_gnt[1]), 32'd1);
        tick(); d_req[1] = 1'b0;
        idle(6);
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h40; d_wdata[1] = 32'h12345678; d_funct3[1] = 3'b010;
        #1 chk(1, "s2_d_gnt_c0", 32'(d_gnt[1]), 32'd1);
        tick();
        d_req[1] = 1'b0; d_we[1] = 1'b0; d_addr[1] = 32'hFFFF_FFF0; d_wdata[1] = 32'h0; d_funct3[1] = 3'b111;
        #1 chk(1, "s2_mem_en_c1", 32'(mem_en[1]), 32'd1);
        chk(1, "s2_mem_we_c1", 32'(mem_we[1]), 32'd1);
        chk(1, "s2_mem_addr_c1", mem_addr[1], 32'h40);
        chk(1, "s2_mem_wdata_c1", mem_wdata[1], 32'h12345678);
        chk(1, "s2_mem_funct3_c1", 32'(mem_funct3[1]), 32'd2);
        tick();
        #1 chk(1, "s2_mem_en_c2", 32'(mem_en[1]), 32'd0);
        chk(1, "s2_mem_addr_c2", mem_addr[1], 32'h40);
        idle(2);
        #1 chk(1, "s2_d_rvalid_c4", 32'(d_rvalid[1]), 32'd1);
        chk(1, "s2_d_rdata_c4", d_rdata[1], 32'h0);
        chk(1, "s2_if_rvalid_c4", 32'(if_rvalid[1]), 32'd0);
        idle(3);

        // Both ports held high at MEM_LAT=1
        if_req[0] = 1'b1; if_addr[0] = 32'h300;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80; d_funct3[0] = 3'b000;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            #1;
            if (if_gnt[0] || d_gnt[0]) begin
                gport[ng] = d_gnt[0];
                gtime[ng] = cyc;
                ng++;
            end
            tick();
        end
        chk(0, "s3_grant_count", 32'(ng), 32'd6);
        for (int n = 0; n < ng; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk(0, $sformatf("s3_grant%0d_is_data", n), 32'(gport[n]), 32'(n % 2 == 0));
`else
            chk(0, $sformatf("s3_grant%0d_is_data", n), 32'(gport[n]), 32'd1);
`endif
            if (n > 0) chk(0, $sformatf("s3_spacing%0d", n), 32'(gtime[n] - gtime[n-1]), 32'd3);
        end
        d_req[0] = 1'b0;
        seen_i = 1'b0;
        for (int c = 0; c < 10 && !seen_i; c++) begin
            #1 seen_i = if_gnt[0];
            tick();
        end
        chk(0, "s3_fetch_after_drop", 32'(seen_i), 32'd1);
        if_req[0] = 1'b0;
        idle(4);

        // Reset pulse during WAIT at MEM_LAT=4
        if_req[2] = 1'b1; if_addr[2] = 32'h180;
        #1 chk(2, "s4_if_gnt_c0", 32'(if_gnt[2]), 32'd1);
        idle(3);
        rst_n = 1'b0;
        #1 chk(2, "s4_rst_if_gnt", 32'(if_gnt[2]), 32'd0);
        chk(2, "s4_rst_busy", 32'(busy[2]), 32'd0);
        chk(2, "s4_rst_mem_en", 32'(mem_en[2]), 32'd0);
        chk(2, "s4_rst_mem_addr", mem_addr[2], 32'h0);
        chk(2, "s4_rst_if_rvalid", 32'(if_rvalid[2]), 32'd0);
        chk(1, "s4_rst_d_rdata", d_rdata[1], 32'h0);
        tick();
        rst_n = 1'b1; if_addr[2] = 32'h200;
        if_req[1] = 1'b1; if_addr[1] = 32'h700; d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h500;
        #1 chk(2, "s4_if_gnt_after_release", 32'(if_gnt[2]), 32'd1);
        chk(1, "s4_ptr_reset_d_gnt", 32'(d_gnt[1]), 32'd1);
        chk(1, "s4_ptr_reset_if_gnt", 32'(if_gnt[1]), 32'd0);
        tick();
        if_req[2] = 1'b0; if_req[1] = 1'b0; d_req[1] = 1'b0;
        idle(8);

        // Data request raised and dropped while fetch waits
        if_req[2] = 1'b1; if_addr[2] = 32'h240;
        #1 chk(2, "s5_if_gnt", 32'(if_gnt[2]), 32'd1);
        tick(); if_req[2] = 1'b0;
        tick();
        d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 32'h600; d_wdata[2] = 32'hCAFE0000;
        #1 chk(2, "s5_d_gnt_wait_a", 32'(d_gnt[2]), 32'd0);
        tick(); d_req[2] = 1'b0;
        #1 chk(2, "s5_d_gnt_wait_b", 32'(d_gnt[2]), 32'd0);
        idle(6);
        #1 chk(2, "s5_mem_addr_kept", mem_addr[2], 32'h240);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: address/data width.
REQ-002 SHALL have parameter MEM_LAT, default 1, legal 1..15: memory read latency in cycles from the mem_en cycle to valid mem_rdata.
REQ-003 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have port 0, instruction fetch: if_req in 1; if_addr in D_WIDTH; if_gnt out 1; if_rvalid out 1; if_rdata out D_WIDTH.
REQ-005 SHALL have port 1, data: d_req in 1; d_we in 1; d_addr in D_WIDTH; d_wdata in D_WIDTH; d_funct3 in 3 (load/store size code); d_gnt out 1; d_rvalid out 1; d_rdata out D_WIDTH.
REQ-006 SHALL have the memory side: mem_en out 1; mem_we out 1; mem_addr out D_WIDTH; mem_wdata out D_WIDTH; mem_funct3 out 3; mem_rdata in D_WIDTH.
REQ-007 SHALL have port busy (out, 1): high while a transaction is in flight.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-009 In IDLE with at least one req high, SHALL assert exactly one gnt combinationally in that cycle, latch the winner's fields on the edge, and enter ACCESS.
REQ-010 Fetch grants SHALL latch we=0, funct3=3'b010 and wdata=0.
REQ-011 In IDLE with no req, SHALL stay in IDLE with both gnt low.
REQ-012 ACCESS SHALL last one cycle: mem_en=1, and mem_we/addr/wdata/funct3 driven from the latched fields.
REQ-013 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr, mem_wdata and mem_funct3 SHALL hold the latched values.
REQ-014 WAIT SHALL count MEM_LAT-1 cycles (zero cycles when MEM_LAT=1; ACCESS then goes directly to RESP).
REQ-015 mem_rdata SHALL be registered at the end of cycle ACCESS+MEM_LAT-1 (relative to ACCESS=0).
REQ-016 RESP SHALL last one cycle, pulse rvalid only to the owning port, and drive its rdata with the registered value (0 for writes); then return to IDLE.
REQ-017 gnt-to-rvalid latency SHALL be MEM_LAT+1 cycles; no grant SHALL occur in ACCESS, WAIT or RESP.
REQ-018 Minimum spacing between grants SHALL be MEM_LAT+2 cycles.
REQ-019 A requester not granted SHALL see gnt low and MAY keep req high; a req dropped before grant SHALL be ignored without side effects.
REQ-020 Non-owner rvalid SHALL stay 0; non-owner rdata SHALL hold its last value.
REQ-021 busy SHALL be high in ACCESS, WAIT and RESP, and low in IDLE.
REQ-022 Request inputs changing after grant SHALL NOT affect the transaction in flight.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and clear the counter, the latched fields and both rdata registers to 0; all outputs SHALL be 0.
REQ-024 Reset mid-transaction SHALL abort it: no rvalid is issued, and mem_en is 0 from reset assertion onward.
REQ-025 The round-robin pointer SHALL reset to "last = fetch", so the first simultaneous request goes to data.
REQ-026 After rst_n deasserts, a req SHALL be grantable on the first rising edge.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN SHALL be optional.
REQ-028 With ARB_ROUND_ROBIN_EN defined, a simultaneous if_req/d_req SHALL be granted to the port not granted most recently (pointer updated on every grant); a single requester SHALL always win.
REQ-029 Without ARB_ROUND_ROBIN_EN, the data port SHALL have fixed priority over fetch, and no pointer register SHALL exist.

Verification
REQ-030 MEM_LAT=1, lone if_req, if_addr=0x100, mem_rdata=0xDEADBEEF one cycle after mem_en -> if_gnt at cycle 0, mem_en at cycle 1, if_rvalid with if_rdata=0xDEADBEEF at cycle 2, busy high in cycles 1-2.
REQ-031 MEM_LAT=3, d_req d_we=1 d_addr=0x40 d_wdata=0x12345678 d_funct3=3'b010 -> one mem_en cycle with mem_we=1 and matching fields, d_rvalid at cycle 4 with d_rdata=0, if_rvalid stays 0.
REQ-032 With ARB_ROUND_ROBIN_EN, if_req and d_req held high for 6 transactions -> grant order D,I,D,I,D,I, grants spaced MEM_LAT+2 cycles apart.
REQ-033 Without the macro, the same stimulus -> all grants to D while d_req stays high; I is granted only after d_req drops.
REQ-034 rst_n pulsed low during WAIT (MEM_LAT=4) -> no rvalid is issued, outputs are 0 immediately, and a new if_req is granted on the first edge after release.
REQ-035 d_req raised then dropped while fetch is in WAIT -> no d_gnt and no data-port memory access.
